// File: rtl/multdiv_pkg.sv
// multdiv_pkg: shared state encoding and constants for the multdiv unit
package multdiv_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  localparam int ITER_COUNT = 32;
  localparam logic [31:0] INT_MIN = 32'h8000_0000;
endpackage

// File: rtl/comp_32.sv
// comp_32: 32-bit unsigned magnitude comparator
module comp_32 (
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  output logic        o_eq,
  output logic        o_gt
);
  assign o_eq = i_a == i_b;
  assign o_gt = i_a > i_b;
endmodule

// File: rtl/div_restore_32.sv
// div_restore_32: iterative signed restoring divider, one quotient bit per clock
module div_restore_32
  import multdiv_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter bit SIGNED = 1'b1
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             ctrl_DIV,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY
);
  state_t      r_state;
  logic [5:0]  r_cnt;
  logic [31:0] r_rem, r_q, r_div;
  logic        r_sign, r_dz, r_ovf;
  logic [31:0] w_a_abs, w_b_abs, w_sh, w_sub;
  logic        w_eq, w_gt, w_ge;
  assign w_a_abs = (SIGNED && data_operandA[31]) ? -data_operandA : data_operandA;
  assign w_b_abs = (SIGNED && data_operandB[31]) ? -data_operandB : data_operandB;
  // rem < divisor <= 2^31, so the shifted remainder always fits in 32 bits
  assign w_sh  = {r_rem[30:0], r_q[31]};
  assign w_sub = w_sh - r_div;
  assign w_ge  = w_gt | w_eq;
  comp_32 u_comp (
    .i_a (w_sh),
    .i_b (r_div),
    .o_eq(w_eq),
    .o_gt(w_gt)
  );
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state        <= IDLE;
      r_cnt          <= '0;
      r_rem          <= '0;
      r_q            <= '0;
      r_div          <= '0;
      r_sign         <= 1'b0;
      r_dz           <= 1'b0;
      r_ovf          <= 1'b0;
      data_result    <= '0;
      data_exception <= 1'b0;
      data_resultRDY <= 1'b0;
    end else begin
      data_resultRDY <= 1'b0;
      if (ctrl_DIV) begin
        r_rem   <= '0;
        r_q     <= w_a_abs;
        r_div   <= w_b_abs;
        r_sign  <= SIGNED && (data_operandA[31] ^ data_operandB[31]);
        r_dz    <= data_operandB == '0;
        r_ovf   <= SIGNED && data_operandA == INT_MIN && data_operandB == '1;
        r_cnt   <= '0;
        r_state <= (data_operandB == '0) ? DONE : RUN;
      end else begin
        case (r_state)
          RUN: begin
            r_rem <= w_ge ? w_sub : w_sh;
            r_q   <= {r_q[30:0], w_ge};
            r_cnt <= r_cnt + 6'd1;
            if (r_cnt == 6'(ITER_COUNT - 1)) r_state <= DONE;
          end
          DONE: begin
            data_result    <= r_dz ? '0 : (r_sign ? -r_q : r_q);
            data_exception <= r_dz | r_ovf;
            data_resultRDY <= 1'b1;
            r_state        <= IDLE;
          end
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_div_restore_32.sv
// tb_div_restore_32: randomized self-checking bench against an arithmetic division model
module tb_div_restore_32;
  logic        clock = 1'b0, reset_n = 1'b0, ctrl_DIV = 1'b0;
  logic [31:0] a = '0, b = '0;
  logic [31:0] data_result;
  logic        data_exception, data_resultRDY;
  int          n_cmp = 0, n_bad = 0;

  div_restore_32 dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .ctrl_DIV      (ctrl_DIV),
    .data_operandA (a),
    .data_operandB (b),
    .data_result   (data_result),
    .data_exception(data_exception),
    .data_resultRDY(data_resultRDY)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // {exception, quotient} from signed arithmetic truncating toward zero
  function automatic logic [32:0] model(input logic [31:0] x, input logic [31:0] y);
    longint lx, ly, lq;
    if (y == 0) return {1'b1, 32'h0};
    lx = longint'($signed(x));
    ly = longint'($signed(y));
    lq = lx / ly;
    return {(lq > 64'sd2147483647), 32'(lq)};
  endfunction

  task automatic run(input string tag, input logic [31:0] x, input logic [31:0] y);
    int lat;
    logic [32:0] e;
    logic [31:0] res;
    logic exc;
    lat = 0; res = '0; exc = 1'b0;
    e = model(x, y);
    @(negedge clock); a = x; b = y; ctrl_DIV = 1'b1;
    @(negedge clock); ctrl_DIV = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clock); #1;
      if (data_resultRDY) begin
        lat = k; res = data_result; exc = data_exception;
        break;
      end
    end
    chk({tag, "_lat"}, 32'(lat), (y == 0) ? 32'd1 : 32'd33);
    chk({tag, "_res"}, res, e[31:0]);
    chk({tag, "_exc"}, 32'(exc), 32'(e[32]));
    @(posedge clock); #1;
    chk({tag, "_pulse"}, 32'(data_resultRDY), 32'd0);
  endtask

  initial begin
    int nrdy, rcyc;
    logic [31:0] res, x, y;
    repeat (3) @(posedge clock);
    #1;
    chk("rst_res", data_result, 32'd0);
    chk("rst_exc", 32'(data_exception), 32'd0);
    chk("rst_rdy", 32'(data_resultRDY), 32'd0);
    @(negedge clock); reset_n = 1'b1;

    run("t1", 32'd100, 32'd7);
    run("t2a", -32'sd100, 32'd7);
    run("t2b", 32'd100, -32'sd7);
    run("t2c", -32'sd100, -32'sd7);
    run("t3", 32'd5, 32'd0);
    run("t4a", 32'h8000_0000, 32'hFFFF_FFFF);
    run("t4b", 32'h8000_0000, 32'd1);
    run("t4c", 32'h7FFF_FFFF, 32'h8000_0000);
    run("t4d", 32'h8000_0000, 32'h8000_0000);

    // abort: re-pulse at edge 10 with 9/3
    nrdy = 0; rcyc = 0; res = '0;
    @(negedge clock); a = 32'd1000; b = 32'd3; ctrl_DIV = 1'b1;
    for (int e = 0; e <= 60; e++) begin
      @(posedge clock); #1;
      if (data_resultRDY) begin nrdy++; rcyc = e; res = data_result; end
      @(negedge clock);
      ctrl_DIV = (e == 9);
      if (e == 9) begin a = 32'd9; b = 32'd3; end
    end
    chk("abort_nrdy", 32'(nrdy), 32'd1);
    chk("abort_cyc", 32'(rcyc), 32'd43);
    chk("abort_res", res, 32'd3);

    // reset mid-RUN
    nrdy = 0;
    @(negedge clock); a = 32'd7; b = 32'd7; ctrl_DIV = 1'b1;
    for (int e = 0; e <= 45; e++) begin
      @(posedge clock); #1;
      if (data_resultRDY) nrdy++;
      @(negedge clock);
      ctrl_DIV = 1'b0;
      if (e == 19) reset_n = 1'b0;
    end
    #1;
    chk("rstrun_nrdy", 32'(nrdy), 32'd0);
    chk("rstrun_res", data_result, 32'd0);
    chk("rstrun_exc", 32'(data_exception), 32'd0);
    @(negedge clock); reset_n = 1'b1;
    run("rstrun_new", 32'd7, 32'd7);

    for (int i = 0; i < 60; i++) begin
      x = $urandom;
      case ($urandom_range(0, 3))
        0: y = $urandom;
        1: y = 32'($urandom_range(0, 16)) - 32'd8;
        2: y = (i % 2) ? 32'h8000_0000 : 32'hFFFF_FFFF;
        default: y = $urandom >> $urandom_range(1, 31);
      endcase
      if (i % 7 == 0) x = 32'h8000_0000;
      run("rand", x, y);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
